// File: rtl/dice_judge.sv
// Two-player dice referee: debounced button starts a roll/settle/score round,
// scores ROUNDS rounds, then parks the generators via finish and reports the winner.
module dice_judge #(
  parameter int ROUNDS   = 5,
  parameter int ROLL_W   = 4,
  parameter int SETTLE_W = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  input  logic [3:0] i_dice_a,
  input  logic [3:0] i_dice_b,
  output logic       o_roll,
  output logic       o_finish,
  output logic [3:0] o_score_a,
  output logic [3:0] o_score_b,
  output logic [3:0] o_round,
  output logic [3:0] o_last_a,
  output logic [3:0] o_last_b,
  output logic [1:0] o_winner,
  output logic       o_err
);
  localparam int CMAX = (ROLL_W > SETTLE_W) ? ROLL_W : SETTLE_W;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ROLL, S_SETTLE, S_SCORE, S_DONE} state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_sync0, r_sync1, r_sync_prev;
  logic          r_roll, r_finish, r_err;
  logic [3:0]    r_score_a, r_score_b, r_round, r_last_a, r_last_b;
  logic [1:0]    r_winner;

  logic          w_press, w_legal, w_a_gt, w_b_gt;
  logic [3:0]    w_rnd_inc, w_sa_new, w_sb_new;
  logic [1:0]    w_win;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync0     <= 1'b0;
      r_sync1     <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync0     <= i_btn;
      r_sync1     <= r_sync0;
      r_sync_prev <= r_sync1;
    end
  end

  assign w_press   = r_sync1 & ~r_sync_prev;
  assign w_legal   = (i_dice_a >= 4'd1) && (i_dice_a <= 4'd9) &&
                     (i_dice_b >= 4'd1) && (i_dice_b <= 4'd9);
  assign w_a_gt    = i_dice_a > i_dice_b;
  assign w_b_gt    = i_dice_b > i_dice_a;
  assign w_rnd_inc = r_round + 4'd1;
  assign w_sa_new  = r_score_a + {3'b000, w_a_gt};
  assign w_sb_new  = r_score_b + {3'b000, w_b_gt};
  // Winner is taken from the post-round scores so it is valid on DONE entry.
  assign w_win     = (w_sa_new > w_sb_new) ? 2'b01 :
                     (w_sb_new > w_sa_new) ? 2'b10 : 2'b11;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: if (w_press) begin
        w_nxt     = S_ROLL;
        w_cnt_nxt = CW'(ROLL_W - 1);
      end
      S_ROLL: if (r_cnt == '0) begin
        w_nxt     = S_SETTLE;
        w_cnt_nxt = CW'(SETTLE_W - 1);
      end else begin
        w_cnt_nxt = r_cnt - 1'b1;
      end
      S_SETTLE: if (r_cnt == '0) w_nxt = S_SCORE;
                else             w_cnt_nxt = r_cnt - 1'b1;
      S_SCORE: begin
        if (w_legal && (w_rnd_inc == 4'(ROUNDS))) w_nxt = S_DONE;
        else                                      w_nxt = S_IDLE;
      end
      S_DONE: if (w_press) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_roll    <= 1'b0;
      r_finish  <= 1'b0;
      r_err     <= 1'b0;
      r_score_a <= '0;
      r_score_b <= '0;
      r_round   <= '0;
      r_last_a  <= '0;
      r_last_b  <= '0;
      r_winner  <= '0;
    end else begin
      r_roll   <= (w_nxt == S_ROLL);
      r_finish <= (w_nxt == S_DONE);
      if (r_state == S_SCORE) begin
        if (!w_legal) begin
          r_err <= 1'b1;
        end else begin
          r_last_a  <= i_dice_a;
          r_last_b  <= i_dice_b;
          r_score_a <= w_sa_new;
          r_score_b <= w_sb_new;
          r_round   <= w_rnd_inc;
          if (w_rnd_inc == 4'(ROUNDS)) r_winner <= w_win;
        end
      end else if ((r_state == S_DONE) && w_press) begin
        r_err     <= 1'b0;
        r_score_a <= '0;
        r_score_b <= '0;
        r_round   <= '0;
        r_last_a  <= '0;
        r_last_b  <= '0;
        r_winner  <= '0;
      end
    end
  end

  assign o_roll    = r_roll;
  assign o_finish  = r_finish;
  assign o_score_a = r_score_a;
  assign o_score_b = r_score_b;
  assign o_round   = r_round;
  assign o_last_a  = r_last_a;
  assign o_last_b  = r_last_b;
  assign o_winner  = r_winner;
  assign o_err     = r_err;
endmodule

// File: doc/dice_judge.md
# dice_judge

Game controller that drives two dice generators and referees a fixed-length match between player A and player B. Each round, a debounced button press makes the block pulse `roll` and wait for the dice values to settle. It then samples both dice, awards a point to the higher value and counts the round. After `ROUNDS` rounds it raises `finish`, which parks both generators at 9, and reports the winner. It sits between the button/debounce logic and the two `random`/`random2` generators, and it feeds the score and winner display.

## Interface
- `ROUNDS`, 5, rounds per match; legal range 1–15.
- `ROLL_W`, 4, `roll` high time in clk cycles; must be ≥1.
- `SETTLE_W`, 4, wait after `roll` falls before dice are sampled; must be ≥1.
- `clk` in 1: system clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `btn` in 1: debounced, asynchronous player button.
- `dice_a` in 4: player A die value; legal values are 1–9.
- `dice_b` in 4: player B die value; legal values are 1–9.
- `roll` out 1: roll strobe to both generators; registered.
- `finish` out 1: match over; drives both generators' `finish` input; registered.
- `score_a` out 4: player A points.
- `score_b` out 4: player B points.
- `round` out 4: rounds completed.
- `last_a` out 4: die A value sampled in the most recent valid round.
- `last_b` out 4: die B value sampled in the most recent valid round.
- `winner` out 2: 00 none, 01 A, 10 B, 11 draw.
- `err` out 1: sticky; set when an illegal die value is sampled.

## Operation
- `btn` passes through a 2-FF synchronizer. A rising edge (`sync1 & ~sync_prev`) produces a one-cycle `press`.
- FSM states: IDLE, ROLL, SETTLE, SCORE, DONE.
- IDLE: on `press`, go to ROLL and load the counter with `ROLL_W-1`.
- ROLL: `roll` = 1. When the counter reaches 0, go to SETTLE and load the counter with `SETTLE_W-1`.
- SETTLE: `roll` = 0. When the counter reaches 0, go to SCORE.
- SCORE (1 cycle): sample `dice_a` and `dice_b`.
  - Either value 0 or >9: set `err`, leave scores, `round` and `last_*` unchanged, return to IDLE. The round is repeated.
  - Otherwise:
    - `last_a`/`last_b` ← sampled values.
    - If a > b, `score_a`++. If b > a, `score_b`++. On equal values, no change.
    - `round`++.
    - If the new `round` == `ROUNDS`, go to DONE; else go to IDLE.
- DONE:
  - `finish` = 1.
  - `winner` = 01 if `score_a` > `score_b`, 10 if `score_b` > `score_a`, 11 if equal.
  - On `press`: clear `score_a`, `score_b`, `round`, `last_a`, `last_b`, `winner` and `err`; drive `finish` = 0; go to IDLE. This starts a new match.
- `press` in ROLL, SETTLE or SCORE is dropped. It is not queued.
- `roll` and `finish` are never high in the same cycle. `finish` falls before any subsequent `roll` rises, because IDLE always lies between them.
- Scores never exceed `ROUNDS`, so 4 bits cannot wrap.

## Timing
- Reset: all outputs are 0 (`roll`, `finish`, `score_a`, `score_b`, `round`, `last_a`, `last_b`, `winner`, `err`). The FSM enters IDLE, the synchronizer and counter clear, and this takes effect immediately and asynchronously.
- Reset asserted mid-round or in DONE: `roll` and `finish` drop at once. No partial score is kept.
- Press latency: `btn` rises before edge 0. `press` is high in the cycle after edge 1. `roll` rises at edge 2.
- `roll` stays high for exactly `ROLL_W` cycles. It is then low for `SETTLE_W` cycles, followed by 1 SCORE cycle.
- Scores, `round` and `last_*` update at the edge that ends SCORE.
- `finish` and `winner` are valid from the edge that enters DONE. `finish` falls one edge after the `press` seen in DONE.
- Minimum round period: 2 sync cycles + `ROLL_W` + `SETTLE_W` + 1 + 1 IDLE cycle.

## Test plan
- Reset, then one press with dice_a=7, dice_b=3 → `roll` high 4 cycles starting 2 cycles after `btn`; after SCORE, `score_a`=1, `score_b`=0, `round`=1, `last_a`=7, `last_b`=3.
- Tie round with dice 5/5 → `round`=1, both scores 0.
- Five rounds with A winning 3, B winning 1 and one tie → `finish`=1, `winner`=01, `round`=5; an extra press clears everything to 0 and `finish`=0, with `roll` still low.
- dice_a=0 (and separately dice_a=12) during SCORE → `err`=1, `round` unchanged; the next valid round still counts.
- Pulse `btn` repeatedly while in ROLL/SETTLE → exactly one `roll` burst and one round counted.
- Drive `rst` low during ROLL and during DONE → `roll`/`finish` are 0 in the same cycle, all counters are 0, and the next press starts at round 0.
